// File: rtl/accu_arb.sv
// Round-robin arbiter that accumulates GROUP_LEN samples from the granted requester into one 10-bit sum.
// Optional stall timeout enabled by defining ACCU_ARB_TIMEOUT_EN.
module accu_arb #(
  parameter int GROUP_LEN   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        out_valid,
  output logic [9:0]  out_data,
  output logic [1:0]  out_id,
  output logic        out_timeout,
  input  logic        out_ready,
  output logic        busy
);

  // state | meaning
  // IDLE  | no group open; arbitrate among req_valid
  // ACC   | accepting samples from grant
  // OUT   | holding result until out_ready
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  if (GROUP_LEN < 1 || GROUP_LEN > 4) begin : g_bad_group_len
    $error("accu_arb: GROUP_LEN must be 1..4");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("accu_arb: TIMEOUT_CYC must be 1..255");
  end

  state_t      state;
  logic [9:0]  sum;
  logic [2:0]  count;
  logic [1:0]  grant;
  logic [1:0]  last_grant;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic [7:0]  gdata;
  logic [9:0]  sum_next;
  logic        xfer;
  logic        count_last;

  // Later iterations overwrite earlier ones, so k=1 (just after last_grant) wins.
  always_comb begin
    pick = last_grant;
    idx  = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (req_valid[idx]) pick = idx;
    end
  end

  assign gdata      = req_data[{grant, 3'b000} +: 8];
  assign sum_next   = sum + {2'b00, gdata};
  assign xfer       = (state == ACC) && req_valid[grant];
  assign count_last = (count == 3'(GROUP_LEN - 1));

  assign req_ready = (state == ACC) ? (4'b0001 << grant) : 4'b0000;
  assign busy      = (state != IDLE);

`ifdef ACCU_ARB_TIMEOUT_EN
  logic [7:0] stall;
  logic       timeout_q;
  logic       stall_hit;
  assign stall_hit   = (stall == 8'(TIMEOUT_CYC - 1));
  assign out_timeout = timeout_q;
`else
  assign out_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sum        <= '0;
      count      <= '0;
      grant      <= '0;
      last_grant <= 2'd3;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
`ifdef ACCU_ARB_TIMEOUT_EN
      stall      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= pick;
            sum   <= '0;
            count <= '0;
            state <= ACC;
`ifdef ACCU_ARB_TIMEOUT_EN
            stall <= '0;
`endif
          end
        end
        ACC: begin
          if (xfer) begin
            sum   <= sum_next;
            count <= count + 3'd1;
`ifdef ACCU_ARB_TIMEOUT_EN
            stall <= '0;
`endif
            if (count_last) begin
              state     <= OUT;
              out_valid <= 1'b1;
              out_data  <= sum_next;
              out_id    <= grant;
`ifdef ACCU_ARB_TIMEOUT_EN
              timeout_q <= 1'b0;
`endif
            end
          end
`ifdef ACCU_ARB_TIMEOUT_EN
          else if (stall_hit) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= sum;
            out_id    <= grant;
            timeout_q <= 1'b1;
          end else begin
            stall <= stall + 8'd1;
          end
`endif
        end
        OUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accu_arb.sv
// Directed bench for accu_arb: expected results come from a round-robin/sum model and are
// scoreboarded against every output handshake, with per-cycle protocol checks.
module tb_accu_arb;

  localparam int GLEN = 4;
  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [9:0]  out_data;
  logic [1:0]  out_id;
  logic        out_timeout;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [9:0] data;
    logic [1:0] id;
    logic       to;
  } res_t;

  res_t exp_q[$];

  accu_arb #(.GROUP_LEN(GLEN), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_timeout(out_timeout), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Round-robin model: first valid requester after 'last', wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
    end
    return last;
  endfunction

  // Per-cycle compare: protocol invariants plus scoreboard on each accepted result.
  logic       pv, pr, pt;
  logic [9:0] pd;
  logic [1:0] pi;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pt = 1'b0; pd = '0; pi = '0;
    end else begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (out_valid) check("ready_zero_in_out", 32'(req_ready), 32'd0);
      if (pv && !pr)
        check("hold_while_stalled", {out_valid, out_data, out_id, out_timeout}, {1'b1, pd, pi, pt});
      if (!out_valid && !pv)
        check("hold_while_invalid", {out_data, out_id}, {pd, pi});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got data=%0d id=%0d to=%0b, expected none",
                   out_data, out_id, out_timeout);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("result", {out_data, out_id, out_timeout}, e);
        end
      end
      pv = out_valid; pr = out_ready; pt = out_timeout; pd = out_data; pi = out_id;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b1;
    exp_q.delete();
    #1;
    check("rst_flags", {out_valid, out_timeout, busy}, 3'b000);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present one sample and return #1 after the edge on which it transferred.
  task automatic send(input int r, input logic [7:0] d);
    bit done;
    done = 1'b0;
    req_valid[r] = 1'b1;
    req_data[8*r +: 8] = d;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [1:0] last, id;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b1;

    check("model_rr_all", 32'(rr_pick(2'd3, 4'hF)), 32'd0);
    check("model_rr_wrap", 32'(rr_pick(2'd0, 4'b1001)), 32'd3);
    check("model_rr_self", 32'(rr_pick(2'd2, 4'b0100)), 32'd2);

    // Requester 0 sends 1,2,3,4 back to back
    do_reset();
    exp_q.push_back('{data: 10'd10, id: 2'd0, to: 1'b0});
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3); send(0, 8'd4);
    req_valid = '0;
    check("t30_out_valid", 32'(out_valid), 32'd1);
    check("t30_out_data", 32'(out_data), 32'd10);
    wait_drain(10, cyc);

    // All four requesters busy with 0xFF: five groups rotate 0,1,2,3,0
    do_reset();
    last = 2'd3;
    for (int k = 0; k < 5; k++) begin
      id = rr_pick(last, 4'hF);
      exp_q.push_back('{data: 10'(GLEN * 255), id: id, to: 1'b0});
      last = id;
    end
    req_data = 32'hFFFF_FFFF;
    req_valid = 4'hF;
    wait_drain(60, cyc);
    req_valid = '0;
    check("t31_spacing", 32'(cyc), 32'(5 * (GLEN + 2)));

    // Output back-pressure for 5 cycles
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back('{data: 10'd260, id: 2'd3, to: 1'b0});
    send(3, 8'd50); send(3, 8'd60); send(3, 8'd70); send(3, 8'd80);
    req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t32_valid_held", {out_valid, busy}, 2'b11);
      check("t32_no_grant", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '0;
    check("t32_out_valid_fell", 32'(out_valid), 32'd0);
    check("t32_accepted", 32'(exp_q.size()), 32'd0);

    // Requester 2 with a 3-cycle gap; requester 1 must be ignored meanwhile
    do_reset();
    exp_q.push_back('{data: 10'd100, id: 2'd2, to: 1'b0});
    send(2, 8'd10); send(2, 8'd20);
    req_valid = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      check("t33_gap_ready", 32'(req_ready), 32'b0100);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    send(2, 8'd30); send(2, 8'd40);
    req_valid = '0;
    wait_drain(10, cyc);

    // Reset mid-group, then requester 0 beats requester 3
    do_reset();
    exp_q.push_back('{data: 10'd10, id: 2'd0, to: 1'b0});
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3); send(0, 8'd4);
    req_valid = '0;
    wait_drain(10, cyc);
    send(1, 8'd7); send(1, 8'd8);
    #3 rst_n = 1'b0;
    #1;
    check("t34_async_flags", {out_valid, out_timeout, busy}, 3'b000);
    check("t34_async_ready", 32'(req_ready), 32'd0);
    check("t34_async_data", 32'(out_data), 32'd0);
    req_valid = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back('{data: 10'd50, id: rr_pick(2'd3, 4'b1001), to: 1'b0});
    req_valid[3] = 1'b1;
    send(0, 8'd11);
    check("t34_grant0", 32'(req_ready), 32'b0001);
    send(0, 8'd12); send(0, 8'd13); send(0, 8'd14);
    req_valid = '0;
    wait_drain(10, cyc);

    // Requester 1 stalls after two samples
    do_reset();
    send(1, 8'd5); send(1, 8'd6);
    req_valid = '0;
`ifdef ACCU_ARB_TIMEOUT_EN
    exp_q.push_back('{data: 10'd11, id: 2'd1, to: 1'b1});
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t35_stall_cycles", 32'(cyc), 32'(TOUT));
    wait_drain(5, cyc);
`else
    repeat (40) @(posedge clk);
    #1;
    check("t35_still_busy", {busy, out_valid}, 2'b10);
    check("t35_still_granted", 32'(req_ready), 32'b0010);
`endif
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accu_arb.md
ACCU_ARB -- requirements
Module: accu_arb

Interface
REQ-001 Parameter GROUP_LEN, default 4, samples per accumulated group; legal range 1..4.
REQ-002 Parameter TIMEOUT_CYC, default 16, consecutive stall cycles before group abort; legal range 1..255; used only with ACCU_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  4  per-requester sample valid; bit i = requester i.
REQ-006 req_data  input  32  per-requester sample; requester i on bits [8i+7:8i], unsigned.
REQ-007 req_ready  output  4  per-requester accept; one-hot or zero; transfer = req_valid[i] & req_ready[i].
REQ-008 out_valid  output  1  group result valid.
REQ-009 out_data  output  10  group sum, unsigned.
REQ-010 out_id  output  2  requester that produced out_data.
REQ-011 out_timeout  output  1  result is a partial sum from an aborted group.
REQ-012 out_ready  input  1  downstream accept; result consumed on out_valid & out_ready.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACC and OUT.
REQ-015 IDLE: if any req_valid bit is high, grant SHALL go to the first set bit searching round-robin from (last_grant+1) mod 4; clear sum and count; next state ACC.
REQ-016 IDLE with req_valid==0 SHALL remain in IDLE with no grant.
REQ-017 req_ready SHALL be onehot(grant) in ACC and 0 in IDLE and OUT; it SHALL be decoded from registered state only, with no combinational path from req_valid.
REQ-018 ACC: each transfer SHALL add req_data of the granted requester to sum (10-bit, no overflow possible for GROUP_LEN<=4) and increment count.
REQ-019 ACC: a cycle without a transfer SHALL hold sum and count; valid on non-granted requesters SHALL be ignored.
REQ-020 ACC: the transfer that makes count equal GROUP_LEN SHALL move to OUT; out_valid SHALL rise the next cycle with out_data = final sum, out_id = grant, out_timeout = 0.
REQ-021 OUT: out_valid, out_data, out_id and out_timeout SHALL hold stable until out_ready is high.
REQ-022 OUT with out_ready high: out_valid SHALL fall next cycle, last_grant SHALL load grant, and the FSM SHALL return to IDLE.
REQ-023 out_data and out_id SHALL keep their last values while out_valid is low.
REQ-024 A requester whose req_valid is high in the same IDLE cycle as a lower-priority one SHALL win regardless of which asserted first.
REQ-025 Minimum group-to-group spacing SHALL be GROUP_LEN+2 cycles (IDLE, GROUP_LEN ACC cycles, OUT).

Reset
REQ-026 While rst_n is low: state IDLE, sum 0, count 0, grant 0, last_grant 3 (requester 0 highest priority first), out_valid 0, out_data 0, out_id 0, out_timeout 0, req_ready 0, busy 0.
REQ-027 Reset asserted mid-group SHALL discard the partial group; no result is emitted for it.

Configuration
REQ-028 Macro ACCU_ARB_TIMEOUT_EN defined: a stall counter SHALL count consecutive ACC cycles without a transfer, clear on each transfer, and on reaching TIMEOUT_CYC move to OUT with out_data = partial sum, out_id = grant, out_timeout = 1.
REQ-029 ACCU_ARB_TIMEOUT_EN undefined: no stall counter; ACC waits indefinitely; out_timeout SHALL be constant 0; port list unchanged.

Verification
REQ-030 Requester 0 only, data 1,2,3,4 on back-to-back cycles, out_ready=1 -> out_valid one cycle after 4th transfer, out_data=10, out_id=0, out_timeout=0.
REQ-031 All four req_valid high, data 8'hFF constant -> four results in order id 0,1,2,3, each out_data=1020, then id 0 again.
REQ-032 out_ready held low 5 cycles during OUT -> out_valid/out_data/out_id stable, req_ready=0, no new grant; result accepted on 6th cycle.
REQ-033 Requester 2 sends 10,20, drops valid 3 cycles, sends 30,40 -> out_data=100, out_id=2; requester 1 valid during gap gets no req_ready.
REQ-034 rst_n pulsed low after 2 transfers -> all outputs at reset values asynchronously; after release requester 0 wins over simultaneous requester 3.
REQ-035 ACCU_ARB_TIMEOUT_EN, TIMEOUT_CYC=16: requester 1 sends 5,6 then stops -> 16 stall cycles later out_valid, out_data=11, out_id=1, out_timeout=1; macro undefined -> stays in ACC, busy=1.
